// File: rtl/memory_2port_clr.sv
`default_nettype none
// ============================================================================
//  Module   : memory_2port_clr
//  Purpose  : Two-port synchronous RAM (A: byte-writable R/W, B: read-only)
//             with a hardware sweep that zeroes the whole array.
//  Revision : 1.0 - initial release
// ============================================================================

module memory_2port_clr #(
    parameter int WIDTH          = 32,
    parameter int ADDR_SIZE      = 10,
    parameter     CONTENT        = "",
    parameter int CLEAR_ON_RESET = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   a_cs,
    input  logic                   a_wen,
    input  logic [WIDTH/8-1:0]     a_be,
    input  logic [ADDR_SIZE-1:0]   a_addr,
    input  logic [WIDTH-1:0]       a_din,
    output logic [WIDTH-1:0]       a_dout,
    input  logic                   b_cs,
    input  logic [ADDR_SIZE-1:0]   b_addr,
    output logic [WIDTH-1:0]       b_dout,
    input  logic                   clr,
    output logic                   busy
);

    localparam int                 c_DEPTH  = 1 << ADDR_SIZE;
    localparam int                 c_NBYTES = WIDTH / 8;
    localparam logic [ADDR_SIZE-1:0] c_LAST = {ADDR_SIZE{1'b1}};

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    logic [WIDTH-1:0]     r_mem [c_DEPTH];
    state_t               r_state;
    logic [ADDR_SIZE-1:0] r_cptr;
    logic                 r_busy;
    logic [WIDTH-1:0]     r_a_dout;
    logic [WIDTH-1:0]     r_b_dout;

    // Power-up image: all cells zero.
    initial begin
        for (int i = 0; i < c_DEPTH; i++) begin
            r_mem[i] = '0;
        end
    end

    // Control FSM and registered read data; reset wins over everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;
            r_busy   <= (CLEAR_ON_RESET != 0);
            r_cptr   <= '0;
            r_a_dout <= '0;
            r_b_dout <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (a_cs) begin
                        r_a_dout <= r_mem[a_addr];
                    end
                    if (b_cs) begin
                        r_b_dout <= r_mem[b_addr];
                    end
                    if (clr) begin
                        r_state <= S_CLEAR;
                        r_busy  <= 1'b1;
                        r_cptr  <= '0;
                    end
                end
                S_CLEAR: begin
                    if (a_cs) begin
                        r_a_dout <= '0;
                    end
                    if (b_cs) begin
                        r_b_dout <= '0;
                    end
                    r_cptr <= r_cptr + 1'b1;
                    if (r_cptr == c_LAST) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Array write port: the sweep owns the array while clearing.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (r_state == S_CLEAR) begin
                r_mem[r_cptr] <= '0;
            end else if (a_cs && a_wen) begin
                for (int i = 0; i < c_NBYTES; i++) begin
                    if (a_be[i]) begin
                        r_mem[a_addr][8*i +: 8] <= a_din[8*i +: 8];
                    end
                end
            end
        end
    end

    assign a_dout = r_a_dout;
    assign b_dout = r_b_dout;
    assign busy   = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_memory_2port_clr.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_memory_2port_clr
//  Purpose  : Self-checking bench: directed vector table, clear / reset
//             sequences, and random traffic against an array-level model.
//  Revision : 1.0 - initial release
// ============================================================================

module tb_memory_2port_clr;

    localparam int c_AW    = 4;
    localparam int c_W     = 32;
    localparam int c_DEPTH = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              a_cs = 1'b0, a_wen = 1'b0, b_cs = 1'b0, clr = 1'b0;
    logic [3:0]        a_be = '0;
    logic [c_AW-1:0]   a_addr = '0, b_addr = '0;
    logic [c_W-1:0]    a_din = '0;
    logic [c_W-1:0]    a_dout, b_dout, a_dout0, b_dout0;
    logic              busy, busy0;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [31:0] m_mem [c_DEPTH];
    logic [31:0] m_a, m_b;
    int          m_left;

    always #5 clk = ~clk;

    memory_2port_clr #(.WIDTH(c_W), .ADDR_SIZE(c_AW), .CLEAR_ON_RESET(1)) dut (
        .clk(clk), .reset(reset), .a_cs(a_cs), .a_wen(a_wen), .a_be(a_be),
        .a_addr(a_addr), .a_din(a_din), .a_dout(a_dout), .b_cs(b_cs),
        .b_addr(b_addr), .b_dout(b_dout), .clr(clr), .busy(busy)
    );

    memory_2port_clr #(.WIDTH(c_W), .ADDR_SIZE(c_AW), .CLEAR_ON_RESET(0)) dut0 (
        .clk(clk), .reset(reset), .a_cs(a_cs), .a_wen(a_wen), .a_be(a_be),
        .a_addr(a_addr), .a_din(a_din), .a_dout(a_dout0), .b_cs(b_cs),
        .b_addr(b_addr), .b_dout(b_dout0), .clr(clr), .busy(busy0)
    );

    function automatic void model_step(input logic r, input logic acs, input logic awen,
                                       input logic [3:0] be, input logic [3:0] aa,
                                       input logic [31:0] din, input logic bcs,
                                       input logic [3:0] ba, input logic c);
        if (r) begin
            m_a    = 0;
            m_b    = 0;
            m_left = c_DEPTH;
            return;
        end
        if (m_left != 0) begin
            if (acs) m_a = 0;
            if (bcs) m_b = 0;
            m_mem[c_DEPTH - m_left] = 0;
            m_left = m_left - 1;
        end else begin
            if (acs) m_a = m_mem[aa];
            if (bcs) m_b = m_mem[ba];
            if (acs && awen) begin
                for (int i = 0; i < 4; i++) begin
                    if (be[i]) m_mem[aa][8*i +: 8] = din[8*i +: 8];
                end
            end
            if (c) m_left = c_DEPTH;
        end
    endfunction

    task automatic tick(input logic r, input logic acs, input logic awen, input logic [3:0] be,
                        input logic [3:0] aa, input logic [31:0] din, input logic bcs,
                        input logic [3:0] ba, input logic c, input string name);
        reset = r; a_cs = acs; a_wen = awen; a_be = be; a_addr = aa;
        a_din = din; b_cs = bcs; b_addr = ba; clr = c;
        model_step(r, acs, awen, be, aa, din, bcs, ba, c);
        @(posedge clk);
        #1;
        n_vec++;
        if (a_dout !== m_a || b_dout !== m_b || busy !== (m_left != 0)) begin
            n_err++;
            $display("FAIL %s: got a=%h b=%h busy=%b, want a=%h b=%h busy=%b",
                     name, a_dout, b_dout, busy, m_a, m_b, (m_left != 0));
        end
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, got, exp);
        end
    endtask

    task automatic fill_all();
        for (int i = 0; i < c_DEPTH; i++) begin
            tick(0, 1, 1, 4'hF, 4'(i), 32'(i + 1) * 32'h01010101, 0, 0, 0, "fill");
        end
    endtask

    task automatic read_all_zero(input string name);
        for (int i = 0; i < c_DEPTH; i++) begin
            tick(0, 1, 0, 0, 4'(i), 0, 1, 4'(c_DEPTH - 1 - i), 0, name);
            check({name, "_a"}, a_dout, 0);
            check({name, "_b"}, b_dout, 0);
        end
    endtask

    typedef struct {
        logic        acs;
        logic        awen;
        logic [3:0]  be;
        logic [3:0]  aa;
        logic [31:0] din;
        logic        bcs;
        logic [3:0]  ba;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
    } vec_t;

    vec_t tbl [17];

    initial begin
        int n;
        for (int i = 0; i < c_DEPTH; i++) m_mem[i] = 0;
        m_a = 0; m_b = 0; m_left = 0;

        tbl[0]  = '{1'b1, 1'b1, 4'hF, 4'd3, 32'hDEADBEEF, 1'b0, 4'd0, 32'h0,        32'h0};
        tbl[1]  = '{1'b1, 1'b0, 4'h0, 4'd3, 32'h0,        1'b1, 4'd3, 32'hDEADBEEF, 32'hDEADBEEF};
        tbl[2]  = '{1'b1, 1'b1, 4'hF, 4'd5, 32'h11223344, 1'b0, 4'd0, 32'h0,        32'hDEADBEEF};
        tbl[3]  = '{1'b1, 1'b1, 4'h5, 4'd5, 32'hAABBCCDD, 1'b0, 4'd0, 32'h11223344, 32'hDEADBEEF};
        tbl[4]  = '{1'b1, 1'b0, 4'h0, 4'd5, 32'h0,        1'b1, 4'd5, 32'h11BB33DD, 32'h11BB33DD};
        tbl[5]  = '{1'b1, 1'b1, 4'hF, 4'd7, 32'h1,        1'b0, 4'd0, 32'h0,        32'h11BB33DD};
        tbl[6]  = '{1'b1, 1'b1, 4'hF, 4'd7, 32'h2,        1'b1, 4'd7, 32'h1,        32'h1};
        tbl[7]  = '{1'b1, 1'b0, 4'h0, 4'd7, 32'h0,        1'b1, 4'd7, 32'h2,        32'h2};
        tbl[8]  = '{1'b1, 1'b1, 4'h0, 4'd7, 32'hFFFFFFFF, 1'b0, 4'd0, 32'h2,        32'h2};
        tbl[9]  = '{1'b1, 1'b0, 4'h0, 4'd7, 32'h0,        1'b0, 4'd0, 32'h2,        32'h2};
        tbl[10] = '{1'b1, 1'b1, 4'hF, 4'd2, 32'h55,       1'b0, 4'd0, 32'h0,        32'h2};
        tbl[11] = '{1'b0, 1'b0, 4'h0, 4'd0, 32'h0,        1'b1, 4'd2, 32'h0,        32'h55};
        tbl[12] = '{1'b0, 1'b0, 4'h0, 4'd0, 32'h0,        1'b0, 4'd9, 32'h0,        32'h55};
        tbl[13] = '{1'b0, 1'b1, 4'hF, 4'd2, 32'h99,       1'b0, 4'd0, 32'h0,        32'h55};
        tbl[14] = '{1'b1, 1'b0, 4'h0, 4'd2, 32'h0,        1'b0, 4'd0, 32'h55,       32'h55};
        tbl[15] = '{1'b1, 1'b1, 4'h8, 4'd5, 32'hFFEEDDCC, 1'b1, 4'd5, 32'h11BB33DD, 32'h11BB33DD};
        tbl[16] = '{1'b1, 1'b0, 4'h0, 4'd5, 32'h0,        1'b0, 4'd0, 32'hFFBB33DD, 32'h11BB33DD};

        // Reset state, then let the power-on sweep finish
        tick(1, 0, 0, 0, 0, 0, 0, 0, 0, "reset");
        check("reset_a", a_dout, 0);
        check("reset_b", b_dout, 0);
        check("reset_busy", 32'(busy), 1);
        check("reset_busy_noclr", 32'(busy0), 0);
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            tick(0, 0, 0, 0, 0, 0, 0, 0, 0, "init_sweep");
        end
        check("init_sweep_len", n, 16);

        // Directed table
        for (int i = 0; i < 17; i++) begin
            tick(0, tbl[i].acs, tbl[i].awen, tbl[i].be, tbl[i].aa, tbl[i].din,
                 tbl[i].bcs, tbl[i].ba, 0, "table");
            check($sformatf("table%0d_a", i), a_dout, tbl[i].exp_a);
            check($sformatf("table%0d_b", i), b_dout, tbl[i].exp_b);
        end

        // Clear sweep with clr held (ignored while busy) and a dropped write
        fill_all();
        tick(0, 1, 0, 0, 4'd4, 0, 0, 0, 1, "clr_start");
        check("clr_start_a", a_dout, 32'h05050505);
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            tick(0, 1, (n == 5), 4'hF, 4'd0, 32'hFFFFFFFF, 1, 4'(n), 1, "clr_sweep");
            if (n <= 16) begin
                check("clr_sweep_a", a_dout, 0);
            end
        end
        check("clr_sweep_len", n, 16);
        read_all_zero("after_clr");

        // Reset five cycles into a sweep restarts it from address 0
        fill_all();
        tick(0, 1, 0, 0, 4'd6, 0, 0, 0, 0, "pre_clr_read");
        tick(0, 0, 0, 0, 0, 0, 0, 0, 1, "clr_start2");
        for (int i = 0; i < 5; i++) tick(0, 0, 0, 0, 0, 0, 0, 0, 0, "mid_sweep");
        check("mid_sweep_a_hold", a_dout, 32'h07070707);
        tick(1, 0, 0, 0, 0, 0, 0, 0, 0, "mid_reset");
        check("mid_reset_a", a_dout, 0);
        check("mid_reset_b", b_dout, 0);
        check("mid_reset_busy", 32'(busy), 1);
        check("mid_reset_busy_noclr", 32'(busy0), 0);
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            tick(0, 1, 1, 4'hF, 4'(n), 32'hA5A5A5A5, 1, 4'(n), 0, "reset_sweep");
        end
        check("reset_sweep_len", n, 16);
        read_all_zero("after_reset_sweep");

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            tick(($urandom % 128) == 0, 1'($urandom), 1'($urandom), 4'($urandom),
                 4'($urandom), $urandom, 1'($urandom), 4'($urandom),
                 ($urandom % 48) == 0, "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
